// File: rtl/cory_pack.sv
// cory_pack: accumulates N-bit beats into a K-slot word with a per-slot mask.
// A word completes on the K-th beat or on a beat tagged last.
`ifndef CORY_PACK_SV
`define CORY_PACK_SV

module cory_pack #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_a_v,
    input  logic [N-1:0]   i_a_d,
    input  logic           i_a_l,
    output logic           o_a_r,
    output logic           o_z_v,
    output logic [N*K-1:0] o_z_d,
    output logic [K-1:0]   o_z_m,
    input  logic           i_z_r
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N*K-1:0] data_q, data_d;
    logic [K-1:0]   mask_q, mask_d;
    logic           in_hs;
    logic           out_hs;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;
        // In HOLD the drain and a fresh beat may share one cycle.
        o_a_r   = (state_q == FILL) ? 1'b1 : i_z_r;
        in_hs   = i_a_v && o_a_r;
        out_hs  = (state_q == HOLD) && i_z_r;

        unique case (state_q)
            FILL: begin
                if (in_hs) begin
                    data_d[cnt_q*N +: N] = i_a_d;
                    mask_d[cnt_q]        = 1'b1;
                    if (cnt_q == CNT_LAST || i_a_l) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_hs) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                    mask_d  = '0;
                    if (in_hs) begin
                        data_d[N-1:0] = i_a_d;
                        mask_d[0]     = 1'b1;
                        if (K == 1 || i_a_l) begin
                            state_d = HOLD;
                        end else begin
                            cnt_d = CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                data_d  = '0;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign o_z_v = (state_q == HOLD);
    assign o_z_d = data_q;
    assign o_z_m = mask_q;

endmodule

`endif

// File: doc/cory_pack.md
CORY_PACK -- requirements
Module: cory_pack

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the input beat width in bits.
REQ-002 The block SHALL have parameter K, default 4, meaning the number of beats per output word (K >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_a_v, input, 1 bit: input beat valid.
REQ-006 The block SHALL have port i_a_d, input, N bits: input beat data.
REQ-007 The block SHALL have port i_a_l, input, 1 bit: last beat of the current word; it forces early word completion.
REQ-008 The block SHALL have port o_a_r, output, 1 bit: input ready.
REQ-009 The block SHALL have port o_z_v, output, 1 bit: packed word valid.
REQ-010 The block SHALL have port o_z_d, output, N*K bits: packed word.
REQ-011 The block SHALL have port o_z_m, output, K bits: per-slot beat-present mask.
REQ-012 The block SHALL have port i_z_r, input, 1 bit: downstream ready.

Function
REQ-013 An input handshake SHALL occur when i_a_v && o_a_r; an output handshake SHALL occur when o_z_v && i_z_r.
REQ-014 The block SHALL have two states: FILL (o_z_v=0) and HOLD (o_z_v=1).
REQ-015 In FILL, o_a_r SHALL be 1, and each accepted beat SHALL be written to slot cnt (bits [cnt*N +: N]), with o_z_m[cnt] set and cnt incremented.
REQ-016 The block SHALL transition from FILL to HOLD on the cycle after the completing beat, which is the accepted beat with cnt==K-1 or with i_a_l=1; cnt SHALL then return to 0.
REQ-017 In HOLD, o_z_d and o_z_m SHALL be held stable, and o_a_r SHALL equal i_z_r (combinational path, full throughput).
REQ-018 In HOLD, on an output handshake without an input handshake, the block SHALL go to FILL and clear o_z_d and o_z_m to 0.
REQ-019 In HOLD, on simultaneous output and input handshakes, the new beat SHALL be written to slot 0 of a fresh word, with all other slots and mask bits zeroed and cnt=1. If that beat is itself completing (K==1 or i_a_l=1), the block SHALL remain in HOLD with the new word.
REQ-020 Unfilled slots of a partial word SHALL read 0, and their o_z_m bits SHALL read 0.
REQ-021 i_a_l SHALL be ignored unless the input handshake occurs.
REQ-022 With K==1, every accepted beat SHALL complete a word, and the block SHALL sustain one word per cycle while i_z_r=1.
REQ-023 Latency SHALL be 1 cycle from the completing-beat handshake to o_z_v=1.
REQ-024 Sustained throughput SHALL be 1 beat per cycle while i_a_v=1 and i_z_r=1.
REQ-025 o_z_v SHALL NOT drop without an output handshake, and o_z_d and o_z_m SHALL NOT change while o_z_v=1 and i_z_r=0.
REQ-026 The cnt width SHALL be clog2(K), minimum 1 bit; cnt SHALL never exceed K-1.

Reset
REQ-027 While reset_n=0, the block SHALL force state=FILL, cnt=0, o_z_v=0, o_z_d=0, and o_z_m=0, asynchronously.
REQ-028 Reset asserted mid-word SHALL discard the partial word with no output.
REQ-029 After reset release, o_a_r SHALL be 1 from the first clock.

Structure
REQ-030 The block SHALL use no shared package; the clog2 counter-width constant SHALL be local to the module, and the block SHALL be included with the same include-guard scheme as the other cory blocks.
REQ-031 The block SHALL be a single module with no sub-module, intended to feed a cory_queue instance of width N*K+K placed downstream by the integrator.

Verification
REQ-032 With N=8, K=4 and i_z_r=1, beats 0x11,0x22,0x33,0x44 SHALL produce o_z_d=0x44332211 and o_z_m=4'b1111, one cycle after the 4th beat.
REQ-033 Beats 0xA1,0xA2 with i_a_l=1 on 0xA2 SHALL produce o_z_d=0x0000A2A1 and o_z_m=4'b0011.
REQ-034 With i_z_r=0 for 5 cycles while a word is in HOLD, o_a_r SHALL be 0, o_z_d SHALL be stable, and no beat SHALL be lost when i_z_r later rises.
REQ-035 Continuous beats 0x01..0x08 with i_z_r=1 SHALL produce 0x04030201 then 0x08070605 with no idle cycle between input beats.
REQ-036 reset_n pulsed low after 2 of 4 beats, followed by beats 0x55,0x66,0x77,0x88, SHALL produce exactly one word, 0x88776655.
REQ-037 With K=1 and i_z_r toggling 1,0,1, a stream of 3 beats SHALL produce 3 words in order, and o_a_r SHALL track i_z_r while in HOLD.
